// File: rtl/merger_leaf_refill_arbiter.sv
// merger_leaf_refill_arbiter
// Refill scheduler for the leaf input FIFOs of a merger tree. One shared
// memory read port is granted to leaves that still have unread run blocks
// and free FIFO credit. Credit is reserved when a leaf is selected and
// returned when the merger pops that leaf's FIFO.
// Optional build macro: REFILL_LOWEST_FIRST_EN. When defined, the grant goes
// to the eligible leaf with the least reserved credit, and ties are broken
// round-robin. When undefined, the grant is pure round-robin.
module merger_leaf_refill_arbiter #(
  parameter int NUM_LEAVES  = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int ADDR_STRIDE = 128,
  parameter int TAG_W       = $clog2(NUM_LEAVES)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [NUM_LEAVES*ADDR_W-1:0] i_base_addr,
  input  logic [NUM_LEAVES*LEN_W-1:0]  i_run_len,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_mem_req_valid,
  input  logic                         i_mem_req_ready,
  output logic [ADDR_W-1:0]            o_mem_req_addr,
  output logic [TAG_W-1:0]             o_mem_req_tag,
  input  logic                         i_mem_resp_valid,
  input  logic [TAG_W-1:0]             i_mem_resp_tag,
  input  logic [NUM_LEAVES-1:0]        i_fifo_read,
  output logic [NUM_LEAVES-1:0]        o_fifo_write
);

  localparam int RES_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(NUM_LEAVES * FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_addr     [NUM_LEAVES];
  logic [LEN_W-1:0]  r_remain   [NUM_LEAVES];
  logic [RES_W-1:0]  r_reserved [NUM_LEAVES];
  logic [OUT_W-1:0]  r_outstanding;
  logic [TAG_W-1:0]  r_rr;

  logic              r_req_valid;
  logic [ADDR_W-1:0] r_req_addr;
  logic [TAG_W-1:0]  r_req_tag;

  logic [NUM_LEAVES-1:0] w_eligible;
  logic [NUM_LEAVES-1:0] w_cand;
  logic [NUM_LEAVES-1:0] w_sel_onehot;
  logic [NUM_LEAVES-1:0] w_pop_ok;
  logic                  w_all_zero;
  logic                  w_accept;
  logic                  w_slot_free;
  logic                  w_sel_found;
  logic                  w_sel_fire;
  logic [TAG_W-1:0]      w_sel_idx;
  logic                  w_resp_ok;
  logic                  w_start;

  assign w_start     = (r_state == S_IDLE) && i_start;
  assign w_accept    = r_req_valid && i_mem_req_ready;
  // The request register can take a new selection when empty or draining this cycle.
  assign w_slot_free = !r_req_valid || w_accept;
  assign w_sel_fire  = w_sel_found && w_slot_free;
  // A response with nothing outstanding is ignored unless an accept lands in the same cycle.
  assign w_resp_ok   = i_mem_resp_valid && (r_state != S_IDLE) &&
                       ((r_outstanding != '0) || w_accept);

  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = (r_state == S_DONE);
  assign o_mem_req_valid = r_req_valid;
  assign o_mem_req_addr  = r_req_addr;
  assign o_mem_req_tag   = r_req_tag;

  // Per-leaf eligibility, pop legality and run-complete detection.
  always_comb begin
    w_eligible = '0;
    w_pop_ok   = '0;
    w_all_zero = 1'b1;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      w_eligible[k] = (r_state == S_RUN) && (r_remain[k] != '0) &&
                      (r_reserved[k] < RES_W'(FIFO_DEPTH));
      w_pop_ok[k]   = (r_state != S_IDLE) && i_fifo_read[k] && (r_reserved[k] != '0);
      if (r_remain[k] != '0) begin
        w_all_zero = 1'b0;
      end else begin
        w_all_zero = w_all_zero;
      end
    end
  end

`ifdef REFILL_LOWEST_FIRST_EN
  logic [RES_W-1:0] w_min_res;

  // Narrow the candidates to the eligible leaves holding the least reserved credit.
  always_comb begin
    w_min_res = '1;
    w_cand    = '0;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      if (w_eligible[k] && (r_reserved[k] < w_min_res)) begin
        w_min_res = r_reserved[k];
      end else begin
        w_min_res = w_min_res;
      end
    end
    for (int k = 0; k < NUM_LEAVES; k++) begin
      w_cand[k] = w_eligible[k] && (r_reserved[k] == w_min_res);
    end
  end
`else
  // Every eligible leaf competes in the round-robin scan.
  always_comb begin
    w_cand = w_eligible;
  end
`endif

  // Round-robin scan over the candidates, starting at the RR pointer.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      if (!w_sel_found && w_cand[(int'(r_rr) + i) % NUM_LEAVES]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = TAG_W'((int'(r_rr) + i) % NUM_LEAVES);
      end else begin
        w_sel_found = w_sel_found;
      end
    end
  end

  // One-hot of the leaf selected this cycle and FIFO enqueue strobes.
  always_comb begin
    w_sel_onehot = '0;
    o_fifo_write = '0;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      w_sel_onehot[k] = w_sel_fire && (w_sel_idx == TAG_W'(k));
      o_fifo_write[k] = (r_state != S_IDLE) && i_mem_resp_valid &&
                        (i_mem_resp_tag == TAG_W'(k));
    end
  end

  // Pass sequencing: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_all_zero && !r_req_valid) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (r_outstanding == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request register: loads on selection, holds until the memory accepts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_tag   <= '0;
    end else if (r_state == S_IDLE) begin
      r_req_valid <= 1'b0;
    end else if (w_sel_fire) begin
      r_req_valid <= 1'b1;
      r_req_addr  <= r_addr[w_sel_idx];
      r_req_tag   <= w_sel_idx;
    end else if (w_accept) begin
      r_req_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the leaf most recently selected.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr <= '0;
    end else if (w_sel_fire) begin
      r_rr <= TAG_W'((int'(w_sel_idx) + 1) % NUM_LEAVES);
    end
  end

  // Per-leaf run cursor, remaining length and reserved FIFO credit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_LEAVES; k++) begin
        r_addr[k]     <= '0;
        r_remain[k]   <= '0;
        r_reserved[k] <= '0;
      end
    end else if (w_start) begin
      for (int k = 0; k < NUM_LEAVES; k++) begin
        r_addr[k]     <= i_base_addr[k*ADDR_W +: ADDR_W];
        r_remain[k]   <= i_run_len[k*LEN_W +: LEN_W];
        r_reserved[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_LEAVES; k++) begin
        if (w_sel_onehot[k]) begin
          r_addr[k]   <= r_addr[k] + ADDR_W'(ADDR_STRIDE);
          r_remain[k] <= r_remain[k] - LEN_W'(1);
        end
        if (w_sel_onehot[k] && !w_pop_ok[k]) begin
          r_reserved[k] <= r_reserved[k] + RES_W'(1);
        end else if (w_pop_ok[k] && !w_sel_onehot[k]) begin
          r_reserved[k] <= r_reserved[k] - RES_W'(1);
        end
      end
    end
  end

  // Outstanding reads: +1 on accept, -1 on a legal response, both cancel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_outstanding <= '0;
    end else if (w_start) begin
      r_outstanding <= '0;
    end else if (w_accept && !w_resp_ok) begin
      r_outstanding <= r_outstanding + OUT_W'(1);
    end else if (w_resp_ok && !w_accept) begin
      r_outstanding <= r_outstanding - OUT_W'(1);
    end
  end

endmodule
